// File: rtl/frame_capture_ctrl_if.sv
// Control, camera-strobe and FIFO write-side signals of the frame capture controller.
// The controller takes the slave modport; the PC/camera/FIFO side takes the master modport.
interface frame_capture_ctrl_if;
  logic        start;
  logic        abort;
  logic        DVAL;
  logic        LVAL;
  logic        fifo_full;
  logic        fifo_rst;
  logic        fifo_wr_en;
  logic        frame_req;
  logic        busy;
  logic        done;
  logic        err_overflow;
  logic        err_timeout;
  logic        err_line_len;
  logic [9:0]  line_count;
  logic [19:0] pixel_count;
  logic [3:0]  State;

  modport master (
    output start, abort, DVAL, LVAL, fifo_full,
    input  fifo_rst, fifo_wr_en, frame_req, busy, done,
           err_overflow, err_timeout, err_line_len,
           line_count, pixel_count, State
  );

  modport slave (
    input  start, abort, DVAL, LVAL, fifo_full,
    output fifo_rst, fifo_wr_en, frame_req, busy, done,
           err_overflow, err_timeout, err_line_len,
           line_count, pixel_count, State
  );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Sequences one camera frame into the image FIFO: FIFO reset, settle, frame request,
// then gated pixel writes with pixel/line accounting and overflow/timeout/line-length errors.
module frame_capture_ctrl #(
  parameter int unsigned PIXELS_PER_LINE = 648,
  parameter int unsigned NUM_LINES       = 488,
  parameter int unsigned RST_CYCLES      = 8,
  parameter int unsigned SETTLE_CYCLES   = 4095,
  parameter int unsigned REQ_CYCLES      = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 16777215
) (
  input logic                 FSM_Clk,
  input logic                 reset,
  frame_capture_ctrl_if.slave bus
);

  localparam int unsigned LINE_W  = 10;
  localparam int unsigned PIX_W   = 20;
  localparam int unsigned SEQ_MAX = (RST_CYCLES > SETTLE_CYCLES)
                                    ? ((RST_CYCLES > REQ_CYCLES) ? RST_CYCLES : REQ_CYCLES)
                                    : ((SETTLE_CYCLES > REQ_CYCLES) ? SETTLE_CYCLES : REQ_CYCLES);
  localparam int unsigned SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int unsigned TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] S_IDLE       = 4'd0;
  localparam logic [3:0] S_FIFO_RST   = 4'd1;
  localparam logic [3:0] S_SETTLE     = 4'd2;
  localparam logic [3:0] S_REQUEST    = 4'd3;
  localparam logic [3:0] S_WAIT_FRAME = 4'd4;
  localparam logic [3:0] S_CAPTURE    = 4'd5;
  localparam logic [3:0] S_DONE       = 4'd6;
  localparam logic [3:0] S_ERROR      = 4'd7;

  logic [3:0]        state_q, state_d;
  logic [SEQ_W-1:0]  seq_cnt_q, seq_cnt_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [PIX_W-1:0]  line_pix_q, line_pix_d;
  logic [PIX_W-1:0]  pixel_count_q, pixel_count_d;
  logic [LINE_W-1:0] line_count_q, line_count_d;
  logic              err_ovf_q, err_ovf_d;
  logic              err_tmo_q, err_tmo_d;
  logic              err_len_q, err_len_d;
  logic              wr_en_q, wr_en_d;
  logic              fifo_rst_q, frame_req_q, busy_q, done_q;
  logic              start_q, lval_q;

  logic start_rise;
  logic pix_valid;
  logic lval_fall;

  assign start_rise = bus.start & ~start_q;
  assign pix_valid  = bus.DVAL & bus.LVAL;
  assign lval_fall  = lval_q & ~bus.LVAL;

  // Next-state and next-counter logic; abort overrides every transition and freezes counters.
  always_comb begin
    state_d       = state_q;
    seq_cnt_d     = seq_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    line_pix_d    = line_pix_q;
    pixel_count_d = pixel_count_q;
    line_count_d  = line_count_q;
    err_ovf_d     = err_ovf_q;
    err_tmo_d     = err_tmo_q;
    err_len_d     = err_len_q;
    wr_en_d       = 1'b0;

    if (bus.abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start_rise) begin
            state_d       = S_FIFO_RST;
            seq_cnt_d     = '0;
            tmo_cnt_d     = '0;
            line_pix_d    = '0;
            pixel_count_d = '0;
            line_count_d  = '0;
            err_ovf_d     = 1'b0;
            err_tmo_d     = 1'b0;
            err_len_d     = 1'b0;
          end
        end
        S_FIFO_RST: begin
          if (seq_cnt_q == SEQ_W'(RST_CYCLES - 1)) begin
            state_d   = S_SETTLE;
            seq_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + SEQ_W'(1);
          end
        end
        S_SETTLE: begin
          if (seq_cnt_q == SEQ_W'(SETTLE_CYCLES - 1)) begin
            state_d   = S_REQUEST;
            seq_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + SEQ_W'(1);
          end
        end
        S_REQUEST: begin
          if (seq_cnt_q == SEQ_W'(REQ_CYCLES - 1)) begin
            state_d   = S_WAIT_FRAME;
            seq_cnt_d = '0;
            tmo_cnt_d = '0;
          end else begin
            seq_cnt_d = seq_cnt_q + SEQ_W'(1);
          end
        end
        S_WAIT_FRAME, S_CAPTURE: begin
          if (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
            state_d   = S_ERROR;
            err_tmo_d = 1'b1;
          end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            if (state_q == S_WAIT_FRAME && bus.LVAL) begin
              state_d = S_CAPTURE;
            end
            // The line counter counts written pixels, so dropped pixels also shorten the line.
            if (pix_valid && bus.fifo_full) begin
              err_ovf_d = 1'b1;
            end else if (pix_valid) begin
              wr_en_d = 1'b1;
              if (pixel_count_q != '1) pixel_count_d = pixel_count_q + PIX_W'(1);
              if (line_pix_q != '1)    line_pix_d    = line_pix_q + PIX_W'(1);
            end
            if (state_q == S_CAPTURE && lval_fall) begin
              line_count_d = line_count_q + LINE_W'(1);
              line_pix_d   = '0;
              if (line_pix_q != PIX_W'(PIXELS_PER_LINE)) err_len_d = 1'b1;
              if (line_count_q == LINE_W'(NUM_LINES - 1)) state_d = S_DONE;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; status outputs are decoded from the next state.
  always_ff @(posedge FSM_Clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      seq_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      line_pix_q    <= '0;
      pixel_count_q <= '0;
      line_count_q  <= '0;
      err_ovf_q     <= 1'b0;
      err_tmo_q     <= 1'b0;
      err_len_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      fifo_rst_q    <= 1'b0;
      frame_req_q   <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      start_q       <= 1'b0;
      lval_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      seq_cnt_q     <= seq_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      line_pix_q    <= line_pix_d;
      pixel_count_q <= pixel_count_d;
      line_count_q  <= line_count_d;
      err_ovf_q     <= err_ovf_d;
      err_tmo_q     <= err_tmo_d;
      err_len_q     <= err_len_d;
      wr_en_q       <= wr_en_d;
      fifo_rst_q    <= (state_d == S_FIFO_RST);
      frame_req_q   <= (state_d == S_REQUEST);
      busy_q        <= !(state_d == S_IDLE || state_d == S_DONE || state_d == S_ERROR);
      done_q        <= (state_d == S_DONE);
      start_q       <= bus.start;
      lval_q        <= bus.LVAL;
    end
  end

  assign bus.fifo_rst     = fifo_rst_q;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.frame_req    = frame_req_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.err_overflow = err_ovf_q;
  assign bus.err_timeout  = err_tmo_q;
  assign bus.err_line_len = err_len_q;
  assign bus.line_count   = line_count_q;
  assign bus.pixel_count  = pixel_count_q;
  assign bus.State        = state_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Self-checking bench for frame_capture_ctrl: scenario table with end-of-frame scoreboard,
// plus hand-written reset, latency and abort sequences. Reduced frame geometry keeps runs short.
module tb_frame_capture_ctrl;

  localparam int unsigned PPL  = 12;
  localparam int unsigned NL   = 6;
  localparam int unsigned RSTC = 8;
  localparam int unsigned SETC = 4095;
  localparam int unsigned REQC = 4;
  localparam int unsigned TMOC = 1000;

  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_WAIT    = 4'd4;
  localparam logic [3:0] ST_CAPTURE = 4'd5;
  localparam logic [3:0] ST_DONE    = 4'd6;
  localparam logic [3:0] ST_ERROR   = 4'd7;

  typedef struct {
    string      name;
    int         ovf_line;
    int         ovf_n;
    int         len_line;
    int         len_pix;
    bit         gaps;
    bit         no_lval;
    bit         exp_done;
    bit         exp_ovf;
    bit         exp_tmo;
    bit         exp_len;
    bit         chk_len;
    int         exp_lines;
    int         exp_pix;
    logic [3:0] exp_state;
    int         exp_wait;
  } vec_t;

  logic FSM_Clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   wr_total = 0;
  vec_t sb[$];
  vec_t tbl[7];

  frame_capture_ctrl_if bus();

  frame_capture_ctrl #(
    .PIXELS_PER_LINE(PPL), .NUM_LINES(NL), .RST_CYCLES(RSTC),
    .SETTLE_CYCLES(SETC), .REQ_CYCLES(REQC), .TIMEOUT_CYCLES(TMOC)
  ) dut (
    .FSM_Clk(FSM_Clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 FSM_Clk = ~FSM_Clk;

  always @(negedge FSM_Clk) if (bus.fifo_wr_en === 1'b1) wr_total++;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input string name, input int ovf_line, input int ovf_n,
                              input int len_line, input int len_pix, input bit gaps,
                              input bit no_lval, input bit e_done, input bit e_ovf,
                              input bit e_tmo, input bit e_len, input bit chk_len,
                              input int e_lines, input int e_pix, input logic [3:0] e_state,
                              input int e_wait);
    vec_t v;
    v.name = name; v.ovf_line = ovf_line; v.ovf_n = ovf_n; v.len_line = len_line;
    v.len_pix = len_pix; v.gaps = gaps; v.no_lval = no_lval; v.exp_done = e_done;
    v.exp_ovf = e_ovf; v.exp_tmo = e_tmo; v.exp_len = e_len; v.chk_len = chk_len;
    v.exp_lines = e_lines; v.exp_pix = e_pix; v.exp_state = e_state; v.exp_wait = e_wait;
    return v;
  endfunction

  task automatic tick(input logic dv, input logic lv, input logic fl);
    @(negedge FSM_Clk);
    bus.DVAL      = dv;
    bus.LVAL      = lv;
    bus.fifo_full = fl;
  endtask

  // Start rise, then measure fifo_rst / settle / frame_req windows; ends in WAIT_FRAME.
  task automatic launch();
    int n;
    bit rst_again;
    rst_again = 1'b0;
    @(negedge FSM_Clk);
    bus.start = 1'b1;
    @(negedge FSM_Clk);
    check("fifo_rst on start", 32'(bus.fifo_rst), 32'd1);
    check("counters cleared", 32'({bus.line_count, bus.pixel_count}), 32'd0);
    check("errors cleared", 32'({bus.err_overflow, bus.err_timeout, bus.err_line_len}), 32'd0);
    check("busy in fifo_rst", 32'(bus.busy), 32'd1);
    n = 0;
    while (bus.fifo_rst && n < 100) begin n++; @(negedge FSM_Clk); end
    check("fifo_rst cycles", 32'(n), 32'(RSTC));
    n = 0;
    while (!bus.frame_req && n < 10000) begin
      if (bus.fifo_rst) rst_again = 1'b1;
      if (n == 100) bus.start = 1'b0;
      if (n == 101) bus.start = 1'b1;
      n++;
      @(negedge FSM_Clk);
    end
    check("settle cycles", 32'(n), 32'(SETC));
    check("no restart while busy", 32'(rst_again), 32'd0);
    n = 0;
    while (bus.frame_req && n < 100) begin n++; @(negedge FSM_Clk); end
    check("frame_req cycles", 32'(n), 32'(REQC));
    check("state wait_frame", 32'(bus.State), 32'(ST_WAIT));
  endtask

  task automatic drive_line(input int npix, input int nfull, input bit gaps);
    for (int p = 0; p < npix; p++) begin
      if (gaps && (p % 3 == 1)) tick(1'b0, 1'b1, 1'b0);
      tick(1'b1, 1'b1, 1'(p < nfull));
    end
    repeat (3) tick(1'b0, 1'b0, 1'b0);
  endtask

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   n;
    int   base;
    sb.push_back(v);
    base = wr_total;
    launch();
    if (!v.no_lval) begin
      for (int l = 0; l < int'(NL); l++)
        drive_line((l == v.len_line) ? v.len_pix : int'(PPL),
                   (l == v.ovf_line) ? v.ovf_n : 0, v.gaps);
    end
    n = 0;
    while (!(bus.done || bus.State == ST_ERROR) && n < 3000) begin n++; @(negedge FSM_Clk); end
    check({v.name, " end reached"}, 32'(n < 3000), 32'd1);
    if (sb.size() == 0) begin
      check({v.name, " scoreboard entry"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      if (e.exp_wait >= 0) check({e.name, " cycles to end"}, 32'(n), 32'(e.exp_wait));
      check({e.name, " done"},         32'(bus.done),         32'(e.exp_done));
      check({e.name, " err_overflow"}, 32'(bus.err_overflow), 32'(e.exp_ovf));
      check({e.name, " err_timeout"},  32'(bus.err_timeout),  32'(e.exp_tmo));
      if (e.chk_len) check({e.name, " err_line_len"}, 32'(bus.err_line_len), 32'(e.exp_len));
      check({e.name, " line_count"},   32'(bus.line_count),   32'(e.exp_lines));
      check({e.name, " pixel_count"},  32'(bus.pixel_count),  32'(e.exp_pix));
      check({e.name, " state"},        32'(bus.State),        32'(e.exp_state));
      check({e.name, " busy"},         32'(bus.busy),         32'd0);
      repeat (10) @(negedge FSM_Clk);
      check({e.name, " held, no retrigger"}, 32'(bus.State), 32'(e.exp_state));
      check({e.name, " fifo writes"}, 32'(wr_total - base), 32'(e.exp_pix));
    end
    bus.start = 1'b0;
    @(negedge FSM_Clk);
  endtask

  initial begin
    tbl[0] = mk("nominal",   -1, 0, -1,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NL, 72, ST_DONE, -1);
    tbl[1] = mk("dval_gaps", -1, 0, -1,  0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NL, 72, ST_DONE, -1);
    tbl[2] = mk("overflow",   2, 3, -1,  0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, NL, 69, ST_DONE, -1);
    tbl[3] = mk("short_line",-1, 0,  1, 11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, NL, 71, ST_DONE, -1);
    tbl[4] = mk("long_line", -1, 0,  4, 13, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, NL, 73, ST_DONE, -1);
    tbl[5] = mk("timeout",   -1, 0, -1,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0,  0, ST_ERROR, int'(TMOC));
    tbl[6] = mk("recover",   -1, 0, -1,  0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, NL, 72, ST_DONE, -1);

    reset = 1'b1;
    bus.start = 1'b0; bus.abort = 1'b0;
    bus.DVAL = 1'b0; bus.LVAL = 1'b0; bus.fifo_full = 1'b0;
    repeat (3) @(negedge FSM_Clk);
    check("reset state", 32'(bus.State), 32'(ST_IDLE));
    check("reset outputs", 32'({bus.fifo_rst, bus.fifo_wr_en, bus.frame_req, bus.busy, bus.done,
                                bus.err_overflow, bus.err_timeout, bus.err_line_len}), 32'd0);
    check("reset counters", 32'({bus.line_count, bus.pixel_count}), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge FSM_Clk);
    check("idle after reset", 32'(bus.State), 32'(ST_IDLE));

    // Asynchronous reset in the middle of line 2.
    launch();
    drive_line(PPL, 0, 1'b0);
    drive_line(PPL, 0, 1'b0);
    for (int p = 0; p < 5; p++) tick(1'b1, 1'b1, 1'b0);
    check("pre-reset pixel_count", 32'(bus.pixel_count), 32'd28);
    check("pre-reset writing", 32'(bus.fifo_wr_en), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid reset state", 32'(bus.State), 32'(ST_IDLE));
    check("mid reset wr/rst", 32'({bus.fifo_wr_en, bus.fifo_rst, bus.busy}), 32'd0);
    check("mid reset counters", 32'({bus.line_count, bus.pixel_count}), 32'd0);
    bus.start = 1'b0; bus.DVAL = 1'b0; bus.LVAL = 1'b0;
    @(negedge FSM_Clk);
    reset = 1'b0;
    repeat (3) @(negedge FSM_Clk);
    check("idle after mid reset", 32'(bus.State), 32'(ST_IDLE));

    // One-cycle write latency on the first pixel, then abort in the middle of line 3.
    launch();
    @(negedge FSM_Clk);
    check("wr_en before first pixel", 32'(bus.fifo_wr_en), 32'd0);
    bus.DVAL = 1'b1; bus.LVAL = 1'b1;
    @(negedge FSM_Clk);
    check("wr_en one cycle later", 32'(bus.fifo_wr_en), 32'd1);
    check("capture entered", 32'(bus.State), 32'(ST_CAPTURE));
    for (int p = 2; p < int'(PPL); p++) tick(1'b1, 1'b1, 1'b0);
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    drive_line(PPL, 0, 1'b0);
    drive_line(PPL, 0, 1'b0);
    for (int p = 0; p < 5; p++) tick(1'b1, 1'b1, 1'b0);
    @(negedge FSM_Clk);
    check("writing before abort", 32'(bus.fifo_wr_en), 32'd1);
    bus.abort = 1'b1;
    @(negedge FSM_Clk);
    check("abort to idle", 32'(bus.State), 32'(ST_IDLE));
    check("abort wr_en/busy", 32'({bus.fifo_wr_en, bus.busy}), 32'd0);
    check("abort holds pixels", 32'(bus.pixel_count), 32'd41);
    check("abort holds lines", 32'(bus.line_count), 32'd3);
    bus.abort = 1'b0; bus.DVAL = 1'b0; bus.LVAL = 1'b0; bus.start = 1'b0;
    repeat (4) @(negedge FSM_Clk);
    check("post-abort idle held", 32'({bus.State, bus.pixel_count}), 32'({ST_IDLE, 20'd41}));

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
